// File: rtl/mod_n_counter.sv
// mod_n_counter: parametrised modulo-N up/down counter.
// Counts through 0..MODULUS-1 with wrap (SATURATE=0) or hold (SATURATE=1)
// at the end of the range. Instances cascade by driving the next stage's
// enable from this stage's terminal output.
//
// Parameters:
//   WIDTH     counter width in bits (2..16)
//   MODULUS   count range 0..MODULUS-1 (2..2**WIDTH)
//   SATURATE  0 = wrap at end of range, 1 = hold at end of range
//
// Ports:
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   enable      in   count step permitted this cycle
//   up_down     in   1 = count up, 0 = count down
//   clear       in   synchronous clear to 0 (highest priority)
//   load        in   synchronous parallel load
//   load_value  in   value applied on load (clamped to MODULUS-1)
//   count       out  current count, registered
//   terminal    out  combinational: enable and count at end of range
//   wrap        out  registered pulse: a wrap happened on the last edge
//   load_error  out  registered pulse: the last load was clamped
module mod_n_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 11,
  parameter int SATURATE = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             wrap,
  output logic             load_error
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("mod_n_counter: WIDTH must be in 2..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_n_counter: MODULUS must be in 2..2**WIDTH");
  end

  // Largest legal count. Computing it here keeps every compare at WIDTH
  // bits, which also covers MODULUS == 2**WIDTH without a wider operand.
  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic             at_max;
  logic             at_zero;
  logic             load_ok;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             load_error_nxt;

  assign at_max   = (count == MAX_COUNT);
  assign at_zero  = (count == '0);
  assign load_ok  = (load_value <= MAX_COUNT);
  assign terminal = enable & (up_down ? at_max : at_zero);

  always_comb begin
    count_nxt      = count;
    wrap_nxt       = 1'b0;
    load_error_nxt = 1'b0;
    if (clear) begin
      count_nxt = '0;
    end else if (load) begin
      if (load_ok) begin
        count_nxt = load_value;
      end else begin
        count_nxt      = MAX_COUNT;
        load_error_nxt = 1'b1;
      end
    end else if (enable) begin
      if (up_down) begin
        if (!at_max) begin
          count_nxt = count + ONE;
        end else if (SATURATE == 0) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_nxt = count - ONE;
        end else if (SATURATE == 0) begin
          count_nxt = MAX_COUNT;
          wrap_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      wrap       <= 1'b0;
      load_error <= 1'b0;
    end else begin
      count      <= count_nxt;
      wrap       <= wrap_nxt;
      load_error <= load_error_nxt;
    end
  end

endmodule

// File: doc/mod_n_counter.md
# mod_n_counter

Parametrised modulo-N counter: the general-purpose successor to the team's fixed 0..10 sequence counter. Counts up or down through 0..MODULUS-1 with wrap or saturate modes. Supports enable, synchronous clear and parallel load, plus registered wrap and combinational terminal-count outputs, so instances cascade into multi-digit timers and sequencers. Default parameters reproduce the 0,1,...,10,0,... sequence when enabled in up mode.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..16.
- MODULUS, 11, count range 0..MODULUS-1; legal range 2..2**WIDTH (elaboration error otherwise).
- SATURATE, 0, 0 = wrap at the end of range; 1 = hold at the end of range.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  count step permitted this cycle.
- up_down  in  1  1 = count up, 0 = count down.
- clear  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_value  in  WIDTH  value applied on load.
- count  out  WIDTH  current count, registered.
- terminal  out  1  combinational; enable AND count at the end of range for the current direction.
- wrap  out  1  registered one-cycle pulse; a wrap occurred on the previous edge.
- load_error  out  1  registered one-cycle pulse; the previous load was out of range and was clamped.

## Operation
- Priority per edge: clear > load > enable step > hold.
- clear: count <= 0. wrap and load_error are 0 on the following cycle.
- load: if load_value < MODULUS, count <= load_value and load_error <= 0. Otherwise count <= MODULUS-1 and load_error <= 1. Load ignores enable and never sets wrap.
- Step up (enable=1, up_down=1):
  - count < MODULUS-1: count+1.
  - count == MODULUS-1: 0 with wrap <= 1 (SATURATE=0), or hold with wrap <= 0 (SATURATE=1).
- Step down (enable=1, up_down=0):
  - count > 0: count-1.
  - count == 0: MODULUS-1 with wrap <= 1 (SATURATE=0), or hold with wrap <= 0 (SATURATE=1).
- terminal = enable & (up_down ? count==MODULUS-1 : count==0). It is asserted even when SATURATE=1, and is independent of clear and load.
- Cascading: drive the next stage's enable from this stage's terminal. Both stages share the same up_down.
- Arithmetic is in WIDTH bits. When MODULUS == 2**WIDTH, the +1/-1 wrap coincides with natural overflow; the behaviour above still holds and wrap is still flagged.
- count never leaves 0..MODULUS-1, by construction.
- Direction change is legal on any cycle; the next step uses the new up_down.

## Timing
- Reset (reset_n low, asynchronous, effective immediately and mid-operation): count=0, wrap=0, load_error=0. Deassertion is synchronised by the integrator; the first step can occur on the first rising edge with reset_n high.
- Latency:
  - Step, load and clear: 1 cycle to count.
  - wrap and load_error: valid in the same cycle as the resulting count, high for exactly one cycle unless the condition repeats.
- terminal: zero-latency combinational path from enable, up_down and count.
- MODULUS=11, WIDTH=4, continuous up-count: wrap is high in the cycle count==0 after 10, every 11 cycles.
- Simultaneous events:
  - clear+load: clear wins, load_error=0.
  - load+enable: load wins, no step.
  - clear during a terminal cycle: no wrap.

## Test plan
- Reset then enable=1, up_down=1 for 24 cycles -> count 0,1..10,0,1..10,0,1; wrap high exactly when count returns to 0 (2 pulses); terminal high while count==10.
- up_down=0 from count 0, enable=1 -> count 10,9,...; wrap on the first cycle (count=10); SATURATE=1 build -> count holds 0, wrap never asserts, terminal stays high.
- load=1, load_value=7 -> count=7, load_error=0; load_value=13 -> count=10, load_error=1 for one cycle; clear+load same cycle -> count=0, load_error=0.
- Assert reset_n low mid-count (count=6) between clock edges -> count=0, wrap=0, load_error=0 immediately, before the next edge.
- Two cascaded instances (MODULUS=10, WIDTH=4), low stage enabled continuously -> high stage increments once per 10 cycles; combined value 00..99 then 00 wraps, with the high stage's wrap pulse at cycle 100.
- Toggle up_down every 3 cycles with enable=1 from count 9 -> count 10,0,1,0,10,9,10,0,1; wrap on each 10<->0 crossing.
